// File: rtl/updown_counter_mod_if.sv
// ---------------------------------------------------------------------------
// updown_counter_mod_if
//
// Purpose:
//   Bundles the control inputs and registered status outputs of the
//   parametrised up/down counter so they travel as a single port.
//
// Signals:
//   en        count enable
//   up_dnb    direction: 1 = up, 0 = down
//   load      synchronous load strobe
//   load_val  value to load (clamped to max_val by the counter)
//   max_val   inclusive terminal value
//   step      increment/decrement magnitude
//   count     registered count
//   tc_up     registered pulse: up-step passed max_val
//   tc_dn     registered pulse: down-step passed 0
//   err       registered pulse: step > max_val in wrap mode
//
// Modports:
//   master  drives the controls and observes the status (user side)
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface updown_counter_mod_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);

  logic              en;
  logic              up_dnb;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  max_val;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              tc_up;
  logic              tc_dn;
  logic              err;

  modport master (
    output en,
    output up_dnb,
    output load,
    output load_val,
    output max_val,
    output step,
    input  count,
    input  tc_up,
    input  tc_dn,
    input  err
  );

  modport slave (
    input  en,
    input  up_dnb,
    input  load,
    input  load_val,
    input  max_val,
    input  step,
    output count,
    output tc_up,
    output tc_dn,
    output err
  );

endinterface

// File: rtl/updown_counter_mod.sv
// ---------------------------------------------------------------------------
// updown_counter_mod
//
// Purpose:
//   General up/down counting primitive with a programmable inclusive
//   terminal value, programmable step, synchronous load and a choice of
//   wrap-around (modulo max_val+1) or saturating behaviour at the bounds.
//   Terminal-count and configuration-error flags are single-cycle pulses
//   registered on the same edge as the count update.
//
// Parameters:
//   WIDTH     counter width; count range is 0..max_val
//   STEP_W    width of the step input (must not exceed WIDTH)
//   SATURATE  0 = wrap modulo (max_val+1), 1 = clamp at bounds
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous, active-high reset
//   bus   updown_counter_mod_if.slave (controls in, count/flags out)
//
// Per-edge priority: load > range clamp > enabled count > hold.
// ---------------------------------------------------------------------------
module updown_counter_mod #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  updown_counter_mod_if.slave bus
);

  localparam int EXT_W = WIDTH + 1;
  localparam bit SAT_MODE = (SATURATE != 0);

  // Registered state
  logic [WIDTH-1:0] count_q;
  logic             tc_up_q;
  logic             tc_dn_q;
  logic             err_q;

  // Next-state values
  logic [WIDTH-1:0] count_d;
  logic             tc_up_d;
  logic             tc_dn_d;
  logic             err_d;

  // Extended operands: one extra bit so no sum or difference truncates.
  logic [EXT_W-1:0] cnt_ext;
  logic [EXT_W-1:0] max_ext;
  logic [EXT_W-1:0] step_ext;
  logic [EXT_W-1:0] sum_up;
  logic [EXT_W-1:0] diff_dn;
  logic [EXT_W-1:0] wrap_up;
  logic [EXT_W-1:0] wrap_dn;
  logic             cfg_err;
  logic             step_nz;

  assign cnt_ext  = {1'b0, count_q};
  assign max_ext  = {1'b0, bus.max_val};
  assign step_ext = EXT_W'(bus.step);
  assign step_nz  = (step_ext != '0);

  // With STEP_W <= WIDTH every intermediate below fits in WIDTH+1 bits:
  // count <= max_val < 2^WIDTH and step < 2^WIDTH.
  assign sum_up  = cnt_ext + step_ext;
  assign diff_dn = cnt_ext - step_ext;
  assign wrap_up = sum_up - (max_ext + EXT_W'(1));
  assign wrap_dn = cnt_ext + max_ext + EXT_W'(1) - step_ext;

  // A step larger than the whole range cannot wrap meaningfully, so in wrap
  // mode it is flagged and the count is clamped like saturate mode instead.
  assign cfg_err = !SAT_MODE && (step_ext > max_ext);

  // Next-state selection. Overflow branches only fire when the count is in
  // range (the clamp branch takes priority), so a wrapped result always
  // lands inside 0..max_val.
  always_comb begin
    count_d = count_q;
    tc_up_d = 1'b0;
    tc_dn_d = 1'b0;
    err_d   = 1'b0;

    if (bus.load) begin
      count_d = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
    end else if (cnt_ext > max_ext) begin
      // max_val was lowered under a running count; pull back silently.
      count_d = bus.max_val;
    end else if (bus.en && step_nz) begin
      if (bus.up_dnb) begin
        if (sum_up <= max_ext) begin
          count_d = WIDTH'(sum_up);
        end else begin
          tc_up_d = 1'b1;
          err_d   = cfg_err;
          if (SAT_MODE || cfg_err) begin
            count_d = bus.max_val;
          end else begin
            count_d = WIDTH'(wrap_up);
          end
        end
      end else begin
        if (step_ext <= cnt_ext) begin
          count_d = WIDTH'(diff_dn);
        end else begin
          tc_dn_d = 1'b1;
          err_d   = cfg_err;
          if (SAT_MODE || cfg_err) begin
            count_d = '0;
          end else begin
            count_d = WIDTH'(wrap_dn);
          end
        end
      end
    end
  end

  // State register; flags are rewritten every edge so they pulse for
  // exactly one cycle unless re-triggered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_up_q <= 1'b0;
      tc_dn_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_up_q <= tc_up_d;
      tc_dn_q <= tc_dn_d;
      err_q   <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc_up = tc_up_q;
  assign bus.tc_dn = tc_dn_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_mod
//
// Directed bench for updown_counter_mod with WIDTH=4, STEP_W=4. Two
// instances share clock and reset: one in wrap mode, one in saturate mode.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_updown_counter_mod;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 4;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  updown_counter_mod_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) w_if ();
  updown_counter_mod_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) s_if ();

  updown_counter_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(0)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (w_if.slave)
  );

  updown_counter_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instance's controls (sel 0 = wrap, 1 = saturate).
  task automatic apply_stimulus(input bit sel, input logic ld, input logic [3:0] lv,
                                input logic [3:0] mx, input logic [3:0] st,
                                input logic e, input logic up);
    if (sel) begin
      s_if.load = ld; s_if.load_val = lv; s_if.max_val = mx;
      s_if.step = st; s_if.en = e;        s_if.up_dnb = up;
    end else begin
      w_if.load = ld; w_if.load_val = lv; w_if.max_val = mx;
      w_if.step = st; w_if.en = e;        w_if.up_dnb = up;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input bit sel, input logic [3:0] ec,
                              input logic eu, input logic ed, input logic ee);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = sel ? {s_if.count, s_if.tc_up, s_if.tc_dn, s_if.err}
              : {w_if.count, w_if.tc_up, w_if.tc_dn, w_if.err};
    exp = {ec, eu, ed, ee};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed count=%0d tc_up=%b tc_dn=%b err=%b expected count=%0d tc_up=%b tc_dn=%b err=%b",
             tag, obs[6:3], obs[2], obs[1], obs[0], ec, eu, ed, ee);
    end
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 9, 0, 0, 1);
    apply_stimulus(1, 0, 0, 15, 0, 0, 1);
    tick();
    tick();
    check_output("reset_wrap", 0, 0, 0, 0, 0);
    check_output("reset_sat", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap count 0..9 then back to 0 with a single tc_up pulse.
    apply_stimulus(0, 0, 0, 9, 1, 1, 1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_output($sformatf("wrap_up_%0d", i), 0, 4'(i), 0, 0, 0);
    end
    tick();
    check_output("wrap_up_9to0", 0, 0, 1, 0, 0);
    tick();
    check_output("wrap_up_after", 0, 1, 0, 0, 0);

    // Wrap down across zero: 1 - 3 -> 8, then 5.
    apply_stimulus(0, 1, 1, 9, 3, 1, 0);
    tick();
    check_output("load_1", 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 9, 3, 1, 0);
    tick();
    check_output("wrap_dn_1to8", 0, 8, 0, 1, 0);
    tick();
    check_output("wrap_dn_8to5", 0, 5, 0, 0, 0);

    // Step of zero with en=1 holds and raises nothing.
    apply_stimulus(0, 0, 0, 9, 0, 1, 1);
    tick();
    check_output("step0_hold", 0, 5, 0, 0, 0);
    apply_stimulus(0, 0, 0, 9, 0, 0, 1);

    // Saturate instance: down to 0 and stick, then up to 15 and stick.
    apply_stimulus(1, 1, 2, 15, 3, 1, 0);
    tick();
    check_output("sat_load_2", 1, 2, 0, 0, 0);
    apply_stimulus(1, 0, 0, 15, 3, 1, 0);
    tick();
    check_output("sat_dn_2to0", 1, 0, 0, 1, 0);
    tick();
    check_output("sat_dn_hold0_a", 1, 0, 0, 1, 0);
    tick();
    check_output("sat_dn_hold0_b", 1, 0, 0, 1, 0);
    apply_stimulus(1, 1, 14, 15, 3, 1, 1);
    tick();
    check_output("sat_load_14", 1, 14, 0, 0, 0);
    apply_stimulus(1, 0, 0, 15, 3, 1, 1);
    tick();
    check_output("sat_up_14to15", 1, 15, 1, 0, 0);
    tick();
    check_output("sat_up_hold15", 1, 15, 1, 0, 0);
    check_output("wrap_idle_hold", 0, 5, 0, 0, 0);

    // Saturate: lowering max_val clamps silently; oversized step never errs.
    apply_stimulus(1, 0, 0, 5, 12, 0, 1);
    tick();
    check_output("sat_clamp_15to5", 1, 5, 0, 0, 0);
    apply_stimulus(1, 0, 0, 5, 12, 1, 1);
    tick();
    check_output("sat_big_step_up", 1, 5, 1, 0, 0);
    apply_stimulus(1, 0, 0, 5, 0, 0, 1);

    // Load above max_val is clamped and wins over en.
    apply_stimulus(0, 1, 12, 9, 1, 1, 1);
    tick();
    check_output("load_clamp_12to9", 0, 9, 0, 0, 0);

    // Runtime max_val reduction with en=0 pulls count down.
    apply_stimulus(0, 1, 11, 15, 1, 0, 1);
    tick();
    check_output("load_11", 0, 11, 0, 0, 0);
    apply_stimulus(0, 0, 0, 5, 1, 0, 1);
    tick();
    check_output("clamp_11to5", 0, 5, 0, 0, 0);
    tick();
    check_output("clamp_hold5", 0, 5, 0, 0, 0);

    // Wrap-mode configuration error: step 12 > max_val 9.
    apply_stimulus(0, 0, 0, 9, 12, 1, 1);
    tick();
    check_output("cfg_err_up", 0, 9, 1, 0, 1);
    apply_stimulus(0, 0, 0, 9, 12, 1, 0);
    tick();
    check_output("cfg_err_dn", 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 9, 12, 0, 0);
    tick();
    check_output("flags_clear", 0, 0, 0, 0, 0);

    // max_val=0: any nonzero step raises tc and count stays 0.
    apply_stimulus(0, 0, 0, 0, 1, 1, 1);
    tick();
    check_output("max0_up", 0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    tick();
    check_output("max0_dn", 0, 0, 0, 1, 1);

    // Asynchronous reset between edges.
    apply_stimulus(0, 1, 7, 9, 1, 0, 1);
    tick();
    check_output("load_7", 0, 7, 0, 0, 0);
    apply_stimulus(0, 0, 0, 9, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_wrap", 0, 0, 0, 0, 0);
    check_output("async_rst_sat", 1, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 9, 1, 1, 1);
    tick();
    check_output("post_rst_up", 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down counter with programmable terminal value, step size, synchronous load, and selectable wrap or saturate mode. It replaces the fixed 4-bit free-running up/down counter as the general counting primitive in neuron timing and phase-step models. It drives registered terminal-count pulses for downstream event logic.

Parameters:
WIDTH, 8, counter width in bits; count range is 0..max_val.
STEP_W, 4, width of the step input.
SATURATE, 0, selects overflow mode: 0 = wrap modulo (max_val+1), 1 = clamp at bounds.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable.
up_dnb  input  1  direction: 1 = up, 0 = down.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value to load.
max_val  input  WIDTH  terminal (upper) value, inclusive.
step  input  STEP_W  increment/decrement magnitude, zero-extended to WIDTH+1.
count  output  WIDTH  registered count.
tc_up  output  1  registered pulse: up-step exceeded max_val.
tc_dn  output  1  registered pulse: down-step went below 0.
err  output  1  registered pulse: step > max_val in wrap mode.

Behaviour:
- Reset: rst=1 asynchronously forces count=0, tc_up=0, tc_dn=0, err=0; held while rst=1. Reset mid-count takes effect immediately, without waiting for a clock edge. The first edge after deassertion evaluates normally.
- Priority per edge: load > range clamp > en > hold.
- Load: count <= min(load_val, max_val). tc_up, tc_dn and err are 0 in that cycle. This holds even if en=1.
- Range clamp: if no load and count > max_val (max_val lowered at runtime), count <= max_val regardless of en. No tc or err is asserted.
- en=0 or step=0: count holds; all flags 0.
- All sums use WIDTH+1 bits; there is no silent truncation.
- Up, sum = count + step:
  - If sum <= max_val: count <= sum.
  - Otherwise, wrap mode: count <= sum - (max_val+1). Saturate mode: count <= max_val. In both cases tc_up=1.
- Down:
  - If step <= count: count <= count - step.
  - Otherwise, wrap mode: count <= count + (max_val+1) - step. Saturate mode: count <= 0. In both cases tc_dn=1.
- Wrap mode with step > max_val: this is a configuration error. The count clamps as in saturate mode for the current direction, and err=1 together with the matching tc.
- Saturate mode held at a bound with en=1 and step>0 toward that bound: count stays and tc repeats every cycle.
- Flags are single-cycle pulses, registered in the same edge as the count update. They return to 0 on the next edge unless re-triggered.
- max_val=0: every enabled nonzero step triggers tc in the given direction; count stays 0.
- Latency: count and flags reflect inputs sampled at the previous posedge (1 cycle).

Test Plan:
1. WIDTH=4, wrap, max_val=9, step=1, en=1, up -> count 0,1,…,9,0; tc_up=1 only on the edge where 9->0.
2. Wrap, max_val=9, count=1, step=3, down -> count=8, tc_dn=1; next edge count=5, tc_dn=0.
3. SATURATE=1, max_val=15, count=2, step=3, down -> count=0, tc_dn=1; holding en=1 keeps count=0 with tc_dn=1 each cycle; up with count=14, step=3 -> count=15, tc_up=1.
4. load=1, load_val=12, max_val=9, en=1, up -> count=9 (load wins, clamped), all flags 0.
5. count=11, max_val changed 15->5, en=0 -> count=5 next edge, flags 0; wrap mode step=12, max_val=9, up -> count=9, tc_up=1, err=1.
6. Assert rst asynchronously between edges at count=7 -> count=0 before the next posedge; after release, up with step=1 -> count=1.
